// File: rtl/alu_reg_if.sv
// Operand/result bundle between the controller and the registered ALU.
interface alu_reg_if #(
    parameter int N = 4
);
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   OP;
    logic         enable;
    logic         s_rst;
    logic [N-1:0] Y;
    logic [2:0]   ONZ;

    // Controller side: drives operands and control, reads back result and flags.
    modport master (
        output A, B, OP, enable, s_rst,
        input  Y, ONZ
    );

    // ALU side: consumes operands and control, presents registered result and flags.
    modport slave (
        input  A, B, OP, enable, s_rst,
        output Y, ONZ
    );
endinterface

// File: rtl/alu_reg.sv
// Registered N-bit two's-complement ALU with overflow/negative/zero flags.
// Result and flags are driven only from flops, so the controller sees the
// previously captured flags throughout the cycle in which enable is high.
module alu_reg #(
    parameter int N = 4
) (
    input logic       clk,
    input logic       rst_n,
    alu_reg_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_PASA = 3'b101,
        OP_ZERO = 3'b110,
        OP_MOVB = 3'b111
    } op_e;

    // Per-cycle mode: either keep the registers or load/clear them.
    typedef enum logic {
        HOLD       = 1'b0,
        LOAD_CLEAR = 1'b1
    } mode_e;

    mode_e        mode;
    logic [N-1:0] result;
    logic         ovf;
    logic [N-1:0] y_q, y_d;
    logic [2:0]   onz_q, onz_d;

    // Combinational ALU: truncated result and signed overflow for ADD/SUB.
    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        result = '0;
        ovf    = 1'b0;
        case (op_e'(bus.OP))
            OP_ADD: begin
                result = bus.A + bus.B;
                ovf    = (bus.A[N-1] == bus.B[N-1]) && (result[N-1] != bus.A[N-1]);
            end
            OP_SUB: begin
                result = bus.A - bus.B;
                ovf    = (bus.A[N-1] != bus.B[N-1]) && (result[N-1] != bus.A[N-1]);
            end
            OP_AND:  result = bus.A & bus.B;
            OP_OR:   result = bus.A | bus.B;
            OP_XOR:  result = bus.A ^ bus.B;
            OP_PASA: result = bus.A;
            OP_ZERO: result = '0;
            OP_MOVB: result = bus.B;
            default: result = '0;
        endcase
    end

    // Next-state selection: s_rst clears, enable loads, otherwise hold.
    always_comb begin
        mode  = (bus.s_rst || bus.enable) ? LOAD_CLEAR : HOLD;
        y_d   = y_q;
        onz_d = onz_q;
        if (mode == LOAD_CLEAR) begin
            if (bus.s_rst) begin
                y_d   = '0;
                onz_d = 3'b000;
            end else begin
                y_d   = result;
                onz_d = {ovf, result[N-1], (result == '0)};
            end
        end
    end

    // Result and flag registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            onz_q <= 3'b000;
        end else begin
            // NOTE: non-blocking assignments so all flops update together at the edge.
            y_q   <= y_d;
            onz_q <= onz_d;
        end
    end

    assign bus.Y   = y_q;
    assign bus.ONZ = onz_q;

endmodule

// File: tb/tb_alu_reg.sv
// Directed self-checking bench for alu_reg with hand-computed vectors.
module tb_alu_reg;

    logic clk;
    logic rst_n;
    int   n_asserts;
    int   n_fails;

    alu_reg_if #(.N(4)) bus ();

    alu_reg #(.N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare Y and ONZ against expected values.
    task automatic check(input string tag, input logic [3:0] y_exp, input logic [2:0] onz_exp);
        n_asserts++;
        assert (bus.Y === y_exp) else begin
            n_fails++;
            $error("FAIL %s Y: observed %b expected %b", tag, bus.Y, y_exp);
        end
        n_asserts++;
        assert (bus.ONZ === onz_exp) else begin
            n_fails++;
            $error("FAIL %s ONZ: observed %b expected %b", tag, bus.ONZ, onz_exp);
        end
    endtask

    // Drive inputs at the falling edge, then wait until just after the rising edge.
    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                         input logic en, input logic sr);
        @(negedge clk);
        bus.A      = a;
        bus.B      = b;
        bus.OP     = op;
        bus.enable = en;
        bus.s_rst  = sr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_asserts  = 0;
        n_fails    = 0;
        rst_n      = 1'b0;
        bus.A      = 4'b0111;
        bus.B      = 4'b0001;
        bus.OP     = 3'b000;
        bus.enable = 1'b1;
        bus.s_rst  = 1'b0;

        // Reset held across edges with enable=1: nothing captured.
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 4'b0000, 3'b000);

        // Release reset; no capture while enable=0.
        @(negedge clk);
        bus.enable = 1'b0;
        rst_n      = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", 4'b0000, 3'b000);

        // ADD positive overflow.
        apply(4'b0111, 4'b0001, 3'b000, 1'b1, 1'b0);
        check("add_ovf_pos", 4'b1000, 3'b110);

        // Hold with unknown OP/A while enable=0.
        apply('x, 4'b0000, 'x, 1'b0, 1'b0);
        check("hold_x_1", 4'b1000, 3'b110);
        apply(4'b0101, 4'b0011, 3'b001, 1'b0, 1'b0);
        check("hold_2", 4'b1000, 3'b110);

        // During an enable cycle the old flags remain visible.
        @(negedge clk);
        bus.A      = 4'b0011;
        bus.B      = 4'b0011;
        bus.OP     = 3'b001;
        bus.enable = 1'b1;
        #1;
        check("pre_op_flags", 4'b1000, 3'b110);
        @(posedge clk);
        #1;
        check("sub_zero", 4'b0000, 3'b001);

        // SUB overflow: negative minus positive goes positive.
        apply(4'b1000, 4'b0001, 3'b001, 1'b1, 1'b0);
        check("sub_ovf", 4'b0111, 3'b100);

        // ADD negative overflow wrapping to zero.
        apply(4'b1000, 4'b1000, 3'b000, 1'b1, 1'b0);
        check("add_ovf_neg", 4'b0000, 3'b101);

        // SUB without overflow, negative result.
        apply(4'b0010, 4'b0101, 3'b001, 1'b1, 1'b0);
        check("sub_neg", 4'b1101, 3'b010);

        // Logic ops, pass A, zero, MOV.
        apply(4'b1100, 4'b1010, 3'b010, 1'b1, 1'b0);
        check("and", 4'b1000, 3'b010);
        apply(4'b0101, 4'b0010, 3'b011, 1'b1, 1'b0);
        check("or", 4'b0111, 3'b000);
        apply(4'b1001, 4'b0110, 3'b101, 1'b1, 1'b0);
        check("pass_a", 4'b1001, 3'b010);
        apply(4'b1111, 4'b1111, 3'b110, 1'b1, 1'b0);
        check("zero_op", 4'b0000, 3'b001);
        apply(4'b0000, 4'b1001, 3'b111, 1'b1, 1'b0);
        check("mov_b", 4'b1001, 3'b010);

        // Y=0101 with overflow flag, then s_rst wins over enable.
        apply(4'b1010, 4'b1011, 3'b000, 1'b1, 1'b0);
        check("add_ovf_0101", 4'b0101, 3'b100);
        apply(4'b0000, 4'b1111, 3'b111, 1'b1, 1'b1);
        check("srst_priority", 4'b0000, 3'b000);

        // s_rst with enable=0 also clears.
        apply(4'b1001, 4'b0000, 3'b101, 1'b1, 1'b0);
        check("pass_a_2", 4'b1001, 3'b010);
        apply(4'b1001, 4'b0000, 3'b101, 1'b0, 1'b1);
        check("srst_no_en", 4'b0000, 3'b000);

        // XOR as NOT, then hold for 3 cycles with MOV set up but disabled.
        apply(4'b1010, 4'b1111, 3'b100, 1'b1, 1'b0);
        check("xor_not", 4'b0101, 3'b000);
        for (int i = 0; i < 3; i++) begin
            apply(4'b1010, 4'b1001, 3'b111, 1'b0, 1'b0);
            check($sformatf("hold_mov_%0d", i), 4'b0101, 3'b000);
        end

        // Async reset mid-cycle with a pending enable.
        apply(4'b1010, 4'b0100, 3'b001, 1'b1, 1'b0);
        check("sub_ovf_0110", 4'b0110, 3'b100);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", 4'b0000, 3'b000);
        @(posedge clk);
        #1;
        check("reset_discard", 4'b0000, 3'b000);
        @(negedge clk);
        rst_n      = 1'b1;
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release", 4'b0000, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
